// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit/receive blocks: state encoding,
// parity modes and board-level timing defaults.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  localparam int unsigned CLK_HZ_DEFAULT   = 50_000_000;
  localparam int unsigned BAUD_DEFAULT     = 115_200;
  localparam int unsigned BAUD_DIV_DEFAULT = 434;

  localparam int unsigned MAX_DATA_BITS = 9;

  // Parity over a word zero-extended to the widest supported frame.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                      input int unsigned mode);
    logic even_bit;
    even_bit = ^data;
    return (mode == PAR_ODD) ? ~even_bit : even_bit;
  endfunction

endpackage : uart_pkg

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..BAUD_DIV-1 while enabled and flags the last
// cycle of each bit. Shared by transmitter and receiver.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear wins over enable so a new frame always starts at count 0.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == CNT_LAST);

endmodule : uart_baud_tick

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start, DATA_BITS data (LSB first), optional
// parity, 1 or 2 stop bits; valid/ready intake and a done pulse per frame.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV  = BAUD_DIV_DEFAULT,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = PAR_NONE,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  input  logic                 Tx_Valid,
  input  logic [DATA_BITS-1:0] Tx_Data,
  output logic                 Tx_Ready,
  output logic                 Tx_Busy,
  output logic                 Tx_Done_Sig,
  output logic                 Tx_Pin_Out
);

  localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS);

  generate
    if (BAUD_DIV < 2 || BAUD_DIV > 65535) begin : g_bad_baud_div
      $error("uart_tx_frame: BAUD_DIV must be 2..65535");
    end
    if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data_bits
      $error("uart_tx_frame: DATA_BITS must be 5..9");
    end
    if (PARITY > PAR_EVEN) begin : g_bad_parity
      $error("uart_tx_frame: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
  endgenerate

  tx_state_e            state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [BIT_W-1:0]     bit_idx_q;
  logic                 par_q;
  logic                 stop_idx_q;
  logic                 pin_q;
  logic                 done_q;

  logic accept;
  logic bit_tick;

  assign accept = Tx_Valid && (state_q == ST_IDLE);

  uart_baud_tick #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_tick (
    .clk     (CLK),
    .rst_n   (RST_n),
    .clear_i (accept),
    .en_i    (state_q != ST_IDLE),
    .tick_o  (bit_tick)
  );

  // Frame sequencer; every state change happens on the last cycle of a bit.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      par_q      <= 1'b0;
      stop_idx_q <= 1'b0;
      pin_q      <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          pin_q <= 1'b1;
          if (Tx_Valid) begin
            shift_q   <= Tx_Data;
            par_q     <= parity_bit(MAX_DATA_BITS'(Tx_Data), PARITY);
            bit_idx_q <= '0;
            pin_q     <= 1'b0;
            state_q   <= ST_START;
          end
        end
        ST_START: begin
          if (bit_tick) begin
            pin_q     <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_idx_q <= BIT_W'(1);
            state_q   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            if (bit_idx_q == BIT_LAST) begin
              if (PARITY != PAR_NONE) begin
                pin_q   <= par_q;
                state_q <= ST_PARITY;
              end else begin
                pin_q      <= 1'b1;
                stop_idx_q <= 1'b0;
                state_q    <= ST_STOP;
              end
            end else begin
              pin_q     <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_idx_q <= bit_idx_q + BIT_W'(1);
            end
          end
        end
        ST_PARITY: begin
          if (bit_tick) begin
            pin_q      <= 1'b1;
            stop_idx_q <= 1'b0;
            state_q    <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (bit_tick) begin
            if ((STOP_BITS == 2) && !stop_idx_q) begin
              stop_idx_q <= 1'b1;
            end else begin
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          pin_q   <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Ready/busy decode the state register; both are forced low during reset.
  assign Tx_Ready    = RST_n && (state_q == ST_IDLE);
  assign Tx_Busy     = RST_n && (state_q != ST_IDLE);
  assign Tx_Done_Sig = done_q;
  assign Tx_Pin_Out  = pin_q;

endmodule : uart_tx_frame

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: three configurations (8N1, 7E2, 8O1),
// all at BAUD_DIV = 4, with hand-computed line sequences.
module tb_uart_tx_frame;

  logic       clk;
  logic       rst_n;
  logic [2:0] valid;
  logic [7:0] d0;
  logic [6:0] d1;
  logic [7:0] d2;
  logic [2:0] ready;
  logic [2:0] busy;
  logic [2:0] done;
  logic [2:0] pin;

  int n_checks;
  int n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_frame #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_8n1 (
    .CLK(clk), .RST_n(rst_n), .Tx_Valid(valid[0]), .Tx_Data(d0),
    .Tx_Ready(ready[0]), .Tx_Busy(busy[0]), .Tx_Done_Sig(done[0]), .Tx_Pin_Out(pin[0]));

  uart_tx_frame #(.BAUD_DIV(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_7e2 (
    .CLK(clk), .RST_n(rst_n), .Tx_Valid(valid[1]), .Tx_Data(d1),
    .Tx_Ready(ready[1]), .Tx_Busy(busy[1]), .Tx_Done_Sig(done[1]), .Tx_Pin_Out(pin[1]));

  uart_tx_frame #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_8o1 (
    .CLK(clk), .RST_n(rst_n), .Tx_Valid(valid[2]), .Tx_Data(d2),
    .Tx_Ready(ready[2]), .Tx_Busy(busy[2]), .Tx_Done_Sig(done[2]), .Tx_Pin_Out(pin[2]));

  task automatic set_data(input int which, input logic [7:0] d);
    case (which)
      0:       d0 = d;
      1:       d1 = d[6:0];
      default: d2 = d;
    endcase
  endtask

  // Present a word from a negedge; it is accepted on the next posedge.
  task automatic send(input int which, input logic [7:0] d, input bit keep);
    set_data(which, d);
    valid[which] = 1'b1;
    @(posedge clk);
    #1;
    if (!keep) valid[which] = 1'b0;
  endtask

  // Record pin/ready/done at each negedge; index i reflects i+1 edges after accept.
  task automatic capture(input int which, input int n, input int drop_at,
                         input int chg_at, input logic [7:0] chg_val,
                         output logic [127:0] sp, output logic [127:0] sr,
                         output logic [127:0] sd);
    sp = '0;
    sr = '0;
    sd = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sp[i] = pin[which];
      sr[i] = ready[which];
      sd[i] = done[which];
      if (i == drop_at) valid[which] = 1'b0;
      if (i == chg_at) set_data(which, chg_val);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (pin !== 3'b111) begin n_errors++; $display("FAIL rst_pin: got %b expected 111", pin); end
    n_checks++;
    if (done !== 3'b000) begin n_errors++; $display("FAIL rst_done: got %b expected 000", done); end
    n_checks++;
    if (ready !== 3'b000) begin n_errors++; $display("FAIL rst_ready: got %b expected 000", ready); end
    n_checks++;
    if (busy !== 3'b000) begin n_errors++; $display("FAIL rst_busy: got %b expected 000", busy); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ready !== 3'b111) begin n_errors++; $display("FAIL rel_ready: got %b expected 111", ready); end
    n_checks++;
    if (busy !== 3'b000) begin n_errors++; $display("FAIL rel_busy: got %b expected 000", busy); end
  endtask

  task automatic test_8n1();
    logic [127:0] sp, sr, sd;
    int e [10];
    e = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    send(0, 8'hA5, 1'b0);
    capture(0, 48, -1, -1, 8'h00, sp, sr, sd);
    for (int b = 0; b < 10; b++) begin
      n_checks++;
      if (sp[4*b +: 4] !== ((e[b] != 0) ? 4'hF : 4'h0)) begin
        n_errors++;
        $display("FAIL 8n1_bit%0d: got %b expected %0d x4", b, sp[4*b +: 4], e[b]);
      end
    end
    n_checks++;
    if (sd[40] !== 1'b1 || $countones(sd) != 1) begin
      n_errors++;
      $display("FAIL 8n1_done: got done[40]=%b count=%0d expected 1/1", sd[40], $countones(sd));
    end
    n_checks++;
    if (sr[39:0] !== 40'h0 || sr[40] !== 1'b1) begin
      n_errors++;
      $display("FAIL 8n1_ready: got %h/%b expected 0/1", sr[39:0], sr[40]);
    end
    n_checks++;
    if (sp[47:40] !== 8'hFF) begin n_errors++; $display("FAIL 8n1_idle: got %h expected ff", sp[47:40]); end
  endtask

  task automatic test_7e2();
    logic [127:0] sp, sr, sd;
    int e [11];
    e = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1};
    send(1, 8'h03, 1'b0);
    capture(1, 50, -1, -1, 8'h00, sp, sr, sd);
    for (int b = 0; b < 11; b++) begin
      n_checks++;
      if (sp[4*b +: 4] !== ((e[b] != 0) ? 4'hF : 4'h0)) begin
        n_errors++;
        $display("FAIL 7e2_bit%0d: got %b expected %0d x4", b, sp[4*b +: 4], e[b]);
      end
    end
    n_checks++;
    if (sd[44] !== 1'b1 || $countones(sd) != 1) begin
      n_errors++;
      $display("FAIL 7e2_done: got done[44]=%b count=%0d expected 1/1", sd[44], $countones(sd));
    end
    n_checks++;
    if (sr[43] !== 1'b0 || sr[44] !== 1'b1) begin
      n_errors++;
      $display("FAIL 7e2_len: got ready[43]=%b ready[44]=%b expected 0/1", sr[43], sr[44]);
    end
  endtask

  task automatic test_odd_parity();
    logic [127:0] sp, sr, sd;
    int e0 [11];
    int e1 [11];
    e0 = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    e1 = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    send(2, 8'h00, 1'b0);
    capture(2, 48, -1, -1, 8'h00, sp, sr, sd);
    for (int b = 0; b < 11; b++) begin
      n_checks++;
      if (sp[4*b +: 4] !== ((e0[b] != 0) ? 4'hF : 4'h0)) begin
        n_errors++;
        $display("FAIL odd00_bit%0d: got %b expected %0d x4", b, sp[4*b +: 4], e0[b]);
      end
    end
    n_checks++;
    if (sd[44] !== 1'b1) begin n_errors++; $display("FAIL odd00_done: got %b expected 1", sd[44]); end
    send(2, 8'hFF, 1'b0);
    capture(2, 48, -1, -1, 8'h00, sp, sr, sd);
    for (int b = 0; b < 11; b++) begin
      n_checks++;
      if (sp[4*b +: 4] !== ((e1[b] != 0) ? 4'hF : 4'h0)) begin
        n_errors++;
        $display("FAIL oddff_bit%0d: got %b expected %0d x4", b, sp[4*b +: 4], e1[b]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] sp, sr, sd;
    int e1 [10];
    int e2 [10];
    e1 = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    e2 = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 1};
    send(0, 8'h55, 1'b1);
    capture(0, 96, 41, 0, 8'h0F, sp, sr, sd);
    for (int b = 0; b < 10; b++) begin
      n_checks++;
      if (sp[4*b +: 4] !== ((e1[b] != 0) ? 4'hF : 4'h0)) begin
        n_errors++;
        $display("FAIL b2b_f1_bit%0d: got %b expected %0d x4", b, sp[4*b +: 4], e1[b]);
      end
      n_checks++;
      if (sp[41 + 4*b +: 4] !== ((e2[b] != 0) ? 4'hF : 4'h0)) begin
        n_errors++;
        $display("FAIL b2b_f2_bit%0d: got %b expected %0d x4", b, sp[41 + 4*b +: 4], e2[b]);
      end
    end
    n_checks++;
    if (sp[40] !== 1'b1 || sr[40] !== 1'b1 || $countones(sr[80:0]) != 1) begin
      n_errors++;
      $display("FAIL b2b_gap: got pin=%b ready=%b readycount=%0d expected 1/1/1",
               sp[40], sr[40], $countones(sr[80:0]));
    end
    n_checks++;
    if (sd[40] !== 1'b1 || sd[81] !== 1'b1 || $countones(sd) != 2) begin
      n_errors++;
      $display("FAIL b2b_done: got d40=%b d81=%b count=%0d expected 1/1/2",
               sd[40], sd[81], $countones(sd));
    end
  endtask

  task automatic test_mid_frame_change();
    logic [127:0] sp, sr, sd;
    int e [10];
    e = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    send(0, 8'hA5, 1'b1);
    capture(0, 48, 15, 10, 8'h5A, sp, sr, sd);
    for (int b = 0; b < 10; b++) begin
      n_checks++;
      if (sp[4*b +: 4] !== ((e[b] != 0) ? 4'hF : 4'h0)) begin
        n_errors++;
        $display("FAIL mid_bit%0d: got %b expected %0d x4", b, sp[4*b +: 4], e[b]);
      end
    end
    n_checks++;
    if (sr[39:0] !== 40'h0 || sr[40] !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_ready: got %h/%b expected 0/1", sr[39:0], sr[40]);
    end
    n_checks++;
    if ($countones(sd) != 1 || sd[40] !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_done: got count=%0d d40=%b expected 1/1", $countones(sd), sd[40]);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [127:0] sp, sr, sd;
    int e [10];
    int done_seen;
    e = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 1};
    done_seen = 0;
    send(0, 8'hA5, 1'b0);
    repeat (18) @(negedge clk);
    n_checks++;
    if (pin[0] !== 1'b0) begin n_errors++; $display("FAIL rmid_bit3: got %b expected 0", pin[0]); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (pin[0] !== 1'b1 || ready[0] !== 1'b0 || busy[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL rmid_abort: got pin=%b ready=%b busy=%b expected 1/0/0", pin[0], ready[0], busy[0]);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done[0] === 1'b1) done_seen++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (done[0] === 1'b1) done_seen++;
    end
    n_checks++;
    if (done_seen != 0) begin n_errors++; $display("FAIL rmid_nodone: got %0d pulses expected 0", done_seen); end
    n_checks++;
    if (ready[0] !== 1'b1 || pin[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL rmid_release: got ready=%b pin=%b expected 1/1", ready[0], pin[0]);
    end
    send(0, 8'h3C, 1'b0);
    capture(0, 44, -1, -1, 8'h00, sp, sr, sd);
    for (int b = 0; b < 10; b++) begin
      n_checks++;
      if (sp[4*b +: 4] !== ((e[b] != 0) ? 4'hF : 4'h0)) begin
        n_errors++;
        $display("FAIL rmid_fresh_bit%0d: got %b expected %0d x4", b, sp[4*b +: 4], e[b]);
      end
    end
    n_checks++;
    if (sd[40] !== 1'b1 || $countones(sd) != 1) begin
      n_errors++;
      $display("FAIL rmid_fresh_done: got d40=%b count=%0d expected 1/1", sd[40], $countones(sd));
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    valid = 3'b000;
    d0 = 8'h00;
    d1 = 7'h00;
    d2 = 8'h00;
    rst_n = 1'b0;
    test_reset();
    test_8n1();
    test_7e2();
    test_odd_parity();
    test_back_to_back();
    test_mid_frame_change();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_uart_tx_frame
